systolic_compute_sequencer: RTL and testbench

Sequencer that owns one compute pass of the 4×4 output-stationary systolic array. It latches operand matrices A and B from the SPI command controller on `start_compute`, clears the PE accumulators, streams skewed rows and columns into the array edges, waits out the pipeline drain, then captures the 16 accumulator results. It signals completion with `compute_done` and a sticky `irq`, and sits between the SPI command controller and the PE array.

---
 rtl/systolic_compute_sequencer.sv | 170 +++++++++++++++++
 tb/tb_systolic_compute_sequencer.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_compute_sequencer.sv
// Compute-pass sequencer for the NxN output-stationary systolic array: latches A/B,
// clears the PEs, feeds skewed edge operands, drains, then captures results.
// Optional cycle counter enabled by defining SYSTOLIC_SEQ_PERF_EN.
module systolic_compute_sequencer #(
    parameter int N            = 4,
    parameter int DW           = 8,
    parameter int AW           = 32,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_compute,
    input  logic [N*N*DW-1:0]   a_flat,
    input  logic [N*N*DW-1:0]   b_flat,
    output logic [N*DW-1:0]     a_west,
    output logic [N*DW-1:0]     b_north,
    output logic                array_en,
    output logic                array_clear,
    input  logic [N*N*AW-1:0]   c_flat,
    output logic [N*N*AW-1:0]   results,
    output logic                busy,
    output logic                compute_done,
    output logic                irq,
    input  logic                irq_clr,
    output logic [15:0]         perf_cycles
);

    localparam int TW  = $clog2(2 * N);
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [TW-1:0]  LAST_T = TW'(2 * N - 2);
    localparam logic [DCW-1:0] LAST_D = DCW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_CAPTURE
    } state_t;

    state_t              state;
    logic [TW-1:0]       feed_t;
    logic [TW-1:0]       feed_next;
    logic [DCW-1:0]      drain_cnt;
    logic [N*N*DW-1:0]   a_reg;
    logic [N*N*DW-1:0]   b_reg;
    logic [N*DW-1:0]     a_feed;
    logic [N*DW-1:0]     b_feed;

    // Edge operands are registered, so compute the skew for the index about to become current.
    always_comb begin
        feed_next = (state == S_FEED) ? feed_t + TW'(1) : '0;
    end

    always_comb begin
        a_feed = '0;
        b_feed = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (TW'(i + k) == feed_next) begin
                    a_feed[i*DW +: DW] = a_reg[(i*N + k)*DW +: DW];
                    b_feed[i*DW +: DW] = b_reg[(k*N + i)*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            feed_t       <= '0;
            drain_cnt    <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            a_west       <= '0;
            b_north      <= '0;
            array_en     <= 1'b0;
            array_clear  <= 1'b0;
            results      <= '0;
            busy         <= 1'b0;
            compute_done <= 1'b0;
            irq          <= 1'b0;
        end else begin
            compute_done <= 1'b0;
            if (irq_clr) begin
                irq <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (start_compute) begin
                        a_reg       <= a_flat;
                        b_reg       <= b_flat;
                        state       <= S_CLEAR;
                        busy        <= 1'b1;
                        array_clear <= 1'b1;
                        array_en    <= 1'b0;
                        a_west      <= '0;
                        b_north     <= '0;
                    end
                end
                S_CLEAR: begin
                    state       <= S_FEED;
                    feed_t      <= '0;
                    array_clear <= 1'b0;
                    array_en    <= 1'b1;
                    a_west      <= a_feed;
                    b_north     <= b_feed;
                end
                S_FEED: begin
                    if (feed_t == LAST_T) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                        a_west    <= '0;
                        b_north   <= '0;
                    end else begin
                        feed_t  <= feed_next;
                        a_west  <= a_feed;
                        b_north <= b_feed;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == LAST_D) begin
                        state    <= S_CAPTURE;
                        array_en <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                S_CAPTURE: begin
                    // Set after the clear above so a coincident irq_clr loses.
                    results      <= c_flat;
                    compute_done <= 1'b1;
                    irq          <= 1'b1;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [15:0] perf_cnt;
    logic [15:0] perf_inc;

    assign perf_inc = (perf_cnt == 16'hFFFF) ? perf_cnt : perf_cnt + 16'd1;

    // Counts every busy cycle; the CAPTURE cycle is included in the published total.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt    <= '0;
            perf_cycles <= '0;
        end else if (state == S_IDLE) begin
            if (start_compute) begin
                perf_cnt <= '0;
            end
        end else begin
            perf_cnt <= perf_inc;
            if (state == S_CAPTURE) begin
                perf_cycles <= perf_inc;
            end
        end
    end
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_compute_sequencer.sv
// Self-checking bench for systolic_compute_sequencer with a behavioural PE array
// and a result scoreboard fed by an independent matrix-multiply model.
module tb_systolic_compute_sequencer;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int AW    = 32;
    localparam int DRAIN = 8;
    localparam int NN    = N * N;
    localparam int PASS  = 2 * N + DRAIN + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_compute;
    logic [NN*DW-1:0]  a_flat;
    logic [NN*DW-1:0]  b_flat;
    logic [N*DW-1:0]   a_west;
    logic [N*DW-1:0]   b_north;
    logic              array_en;
    logic              array_clear;
    logic [NN*AW-1:0]  c_flat;
    logic [NN*AW-1:0]  results;
    logic              busy;
    logic              compute_done;
    logic              irq;
    logic              irq_clr;
    logic [15:0]       perf_cycles;

    int total = 0;
    int bad   = 0;
    logic [NN*AW-1:0] sb [$];

    systolic_compute_sequencer #(
        .N(N), .DW(DW), .AW(AW), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk), .rst(rst), .start_compute(start_compute),
        .a_flat(a_flat), .b_flat(b_flat),
        .a_west(a_west), .b_north(b_north),
        .array_en(array_en), .array_clear(array_clear),
        .c_flat(c_flat), .results(results),
        .busy(busy), .compute_done(compute_done), .irq(irq),
        .irq_clr(irq_clr), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    // Behavioural output-stationary PE array driven by the sequencer's edge operands.
    logic [AW-1:0] acc [N][N];
    logic [DW-1:0] ar  [N][N];
    logic [DW-1:0] br  [N][N];

    always @(posedge clk) begin
        logic [DW-1:0] a_in;
        logic [DW-1:0] b_in;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (rst || array_clear) begin
                    acc[i][j] <= '0;
                    ar[i][j]  <= '0;
                    br[i][j]  <= '0;
                end else if (array_en) begin
                    if (j == 0) a_in = a_west[i*DW +: DW];
                    else        a_in = ar[i][j-1];
                    if (i == 0) b_in = b_north[j*DW +: DW];
                    else        b_in = br[i-1][j];
                    acc[i][j] <= acc[i][j] + AW'(a_in) * AW'(b_in);
                    ar[i][j]  <= a_in;
                    br[i][j]  <= b_in;
                end
            end
        end
    end

    always_comb begin
        c_flat = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                c_flat[(i*N + j)*AW +: AW] = acc[i][j];
    end

    function automatic logic [NN*AW-1:0] matmul(input logic [NN*DW-1:0] a, input logic [NN*DW-1:0] b);
        logic [AW-1:0] s;
        matmul = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int k = 0; k < N; k++)
                    s = s + AW'(a[(i*N + k)*DW +: DW]) * AW'(b[(k*N + j)*DW +: DW]);
                matmul[(i*N + j)*AW +: AW] = s;
            end
        end
    endfunction

    function automatic logic [N*DW-1:0] exp_west(input logic [NN*DW-1:0] a, input int t);
        exp_west = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N)
                exp_west[i*DW +: DW] = a[(i*N + (t - i))*DW +: DW];
    endfunction

    function automatic logic [N*DW-1:0] exp_north(input logic [NN*DW-1:0] b, input int t);
        exp_north = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N)
                exp_north[j*DW +: DW] = b[((t - j)*N + j)*DW +: DW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_compute = 1'b0;
        irq_clr = 1'b0;
        a_flat = '0;
        b_flat = '0;
        repeat (3) step();
        total++;
        if ({busy, compute_done, irq, array_en, array_clear} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags actual=%b expected=00000", {busy, compute_done, irq, array_en, array_clear});
        end
        total++;
        if ({a_west, b_north} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_edges actual=%h expected=0", {a_west, b_north});
        end
        total++;
        if (results !== '0 || perf_cycles !== 16'd0) begin
            bad++;
            $display("[TB] FAIL reset_results actual=%h perf=%0d expected=0", results, perf_cycles);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_identity();
        logic [NN*AW-1:0] exp_res;
        int exp_perf;
`ifdef SYSTOLIC_SEQ_PERF_EN
        exp_perf = 17;
`else
        exp_perf = 0;
`endif
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                a_flat[(i*N + k)*DW +: DW] = (i == k) ? DW'(1) : DW'(0);
                b_flat[(i*N + k)*DW +: DW] = DW'(N*i + k + 1);
            end
        start_compute = 1'b1;
        sb.push_back(matmul(a_flat, b_flat));
        step();
        start_compute = 1'b0;
        for (int n = 1; n <= PASS; n++) begin
            total++;
            if (array_clear !== (n == 1) || array_en !== (n >= 2 && n <= PASS - 2) || busy !== (n < PASS)) begin
                bad++;
                $display("[TB] FAIL ident_ctrl cycle=%0d clear/en/busy actual=%b%b%b", n, array_clear, array_en, busy);
            end
            total++;
            if (compute_done !== (n == PASS)) begin
                bad++;
                $display("[TB] FAIL ident_done cycle=%0d actual=%b expected=%b", n, compute_done, n == PASS);
            end
            if (compute_done === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL ident_sb_empty cycle=%0d", n);
                end else begin
                    exp_res = sb.pop_front();
                    if (results !== exp_res) begin
                        bad++;
                        $display("[TB] FAIL ident_results actual=%h expected=%h", results, exp_res);
                    end
                end
            end
            if (n < PASS) step();
        end
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ident_irq actual=%b expected=1", irq);
        end
        total++;
        if (perf_cycles !== 16'(exp_perf)) begin
            bad++;
            $display("[TB] FAIL perf_cycles actual=%0d expected=%0d", perf_cycles, exp_perf);
        end
        step();
    endtask

    task automatic test_skew();
        logic [NN*DW-1:0] a_saved;
        logic [NN*DW-1:0] b_saved;
        logic [NN*AW-1:0] exp_res;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                a_flat[(i*N + k)*DW +: DW] = DW'(16*i + k);
                b_flat[(i*N + k)*DW +: DW] = DW'($urandom_range(255));
            end
        a_saved = a_flat;
        b_saved = b_flat;
        start_compute = 1'b1;
        sb.push_back(matmul(a_saved, b_saved));
        step();
        start_compute = 1'b0;
        for (int n = 1; n <= PASS; n++) begin
            if (n == 2) begin
                a_flat = {NN*DW/32{$urandom}};
                b_flat = {NN*DW/32{$urandom}};
            end
            if (n >= 2 && n <= 2*N) begin
                total++;
                if (a_west !== exp_west(a_saved, n - 2) || b_north !== exp_north(b_saved, n - 2)) begin
                    bad++;
                    $display("[TB] FAIL skew t=%0d a_west=%h/%h b_north=%h/%h (actual/expected)", n - 2,
                             a_west, exp_west(a_saved, n - 2), b_north, exp_north(b_saved, n - 2));
                end
            end else if (n > 2*N && n < PASS) begin
                total++;
                if ({a_west, b_north} !== '0) begin
                    bad++;
                    $display("[TB] FAIL skew_idle_edges cycle=%0d actual=%h expected=0", n, {a_west, b_north});
                end
            end
            if (n == 2) begin
                total++;
                if (a_west !== 32'h0000_0000) begin
                    bad++;
                    $display("[TB] FAIL skew_t0 actual=%h expected=00000000", a_west);
                end
            end
            if (n == 5) begin
                total++;
                if (a_west !== 32'h3021_1203) begin
                    bad++;
                    $display("[TB] FAIL skew_t3 actual=%h expected=30211203", a_west);
                end
            end
            if (compute_done === 1'b1) begin
                total++;
                if (sb.size() == 0 || n != PASS) begin
                    bad++;
                    $display("[TB] FAIL skew_done cycle=%0d queued=%0d", n, sb.size());
                end else begin
                    exp_res = sb.pop_front();
                    if (results !== exp_res) begin
                        bad++;
                        $display("[TB] FAIL skew_results actual=%h expected=%h", results, exp_res);
                    end
                end
            end
            if (n < PASS) step();
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL skew_no_done queued=%0d expected=0", sb.size());
            sb.delete();
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [NN*AW-1:0] exp_res;
        int dones = 0;
        for (int i = 0; i < NN; i++) begin
            a_flat[i*DW +: DW] = DW'($urandom_range(255));
            b_flat[i*DW +: DW] = DW'($urandom_range(255));
        end
        start_compute = 1'b1;
        sb.push_back(matmul(a_flat, b_flat));
        sb.push_back(matmul(a_flat, b_flat));
        step();
        for (int n = 1; n <= 2*PASS + 4; n++) begin
            total++;
            if (compute_done !== (n == PASS || n == 2*PASS) || array_clear !== (n == 1 || n == PASS + 1)) begin
                bad++;
                $display("[TB] FAIL b2b_timing cycle=%0d done=%b clear=%b", n, compute_done, array_clear);
            end
            if (compute_done === 1'b1) begin
                dones++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL b2b_sb_empty cycle=%0d", n);
                end else begin
                    exp_res = sb.pop_front();
                    if (results !== exp_res) begin
                        bad++;
                        $display("[TB] FAIL b2b_results actual=%h expected=%h", results, exp_res);
                    end
                end
            end
            if (n == PASS + 1) start_compute = 1'b0;
            step();
        end
        total++;
        if (dones != 2 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_count dones=%0d busy=%b expected=2,0", dones, busy);
            sb.delete();
        end
    endtask

    task automatic test_irq();
        logic [NN*AW-1:0] exp_res;
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL irq_clear_idle actual=%b expected=0", irq);
        end
        start_compute = 1'b1;
        sb.push_back(matmul(a_flat, b_flat));
        step();
        start_compute = 1'b0;
        repeat (PASS - 2) step();
        total++;
        if (irq !== 1'b0 || compute_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL irq_early irq=%b done=%b expected=0,0", irq, compute_done);
        end
        irq_clr = 1'b1;
        step();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("[TB] FAIL irq_set_wins actual=%b expected=1", irq);
        end
        total++;
        if (compute_done !== 1'b1 || sb.size() == 0) begin
            bad++;
            $display("[TB] FAIL irq_pass_done actual=%b expected=1", compute_done);
            sb.delete();
        end else begin
            exp_res = sb.pop_front();
            if (results !== exp_res) begin
                bad++;
                $display("[TB] FAIL irq_results actual=%h expected=%h", results, exp_res);
            end
        end
        step();
        irq_clr = 1'b0;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL irq_clear_after actual=%b expected=0", irq);
        end
    endtask

    task automatic test_reset_mid();
        logic [NN*AW-1:0] exp_res;
        int stray = 0;
        start_compute = 1'b1;
        sb.push_back(matmul(a_flat, b_flat));
        step();
        start_compute = 1'b0;
        repeat (PASS - 1) step();
        total++;
        if (compute_done !== 1'b1 || sb.size() == 0) begin
            bad++;
            $display("[TB] FAIL mid_pre_done actual=%b expected=1", compute_done);
            sb.delete();
        end else begin
            exp_res = sb.pop_front();
            if (results !== exp_res) begin
                bad++;
                $display("[TB] FAIL mid_pre_results actual=%h expected=%h", results, exp_res);
            end
        end
        start_compute = 1'b1;
        step();
        start_compute = 1'b0;
        repeat (3) step();
        total++;
        if (a_west !== exp_west(a_flat, 2) || array_en !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_feed_t2 a_west=%h expected=%h en=%b", a_west, exp_west(a_flat, 2), array_en);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({busy, array_en, array_clear, irq, compute_done} !== 5'b0 || results !== '0 || {a_west, b_north} !== '0) begin
            bad++;
            $display("[TB] FAIL mid_reset flags=%b results=%h edges=%h expected=0", {busy, array_en, array_clear, irq, compute_done}, results, {a_west, b_north});
        end
        for (int n = 0; n < 2*PASS; n++) begin
            if (compute_done !== 1'b0 || busy !== 1'b0) stray++;
            step();
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("[TB] FAIL mid_no_done stray_cycles=%0d expected=0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_skew();
        test_back_to_back();
        test_irq();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_leftover actual=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
